// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and FIFO word layout for the write-side FIFO arbiter.
// The FIFO word is {id[2:0], last, payload[31:0]}.
package fifo_wr_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam int WORD_W      = 36;
  localparam int ID_MSB      = 35;
  localparam int ID_LSB      = 33;
  localparam int LAST_BIT    = 32;
  localparam int PAYLOAD_MSB = 31;
  localparam int PAYLOAD_W   = 32;
  localparam int ID_W        = 3;

  function automatic logic [WORD_W-1:0] pack_word(input logic [ID_W-1:0]      id,
                                                  input logic                 last,
                                                  input logic [PAYLOAD_W-1:0] payload);
    logic [WORD_W-1:0] w;
    w                      = '0;
    w[ID_MSB:ID_LSB]       = id;
    w[LAST_BIT]            = last;
    w[PAYLOAD_MSB:0]       = payload;
    return w;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-port bundle for the arbiter.
// The slave modport is the arbiter's view; master is the environment's.
interface fifo_wr_arbiter_if
  import fifo_wr_arb_pkg::*;
#(
  parameter int N = 4
);
  logic [N-1:0]        en_mask;
  logic [N-1:0]        req_valid;
  logic [32*N-1:0]     req_data;
  logic [N-1:0]        req_last;
  logic [N-1:0]        req_ready;
  logic [WORD_W-1:0]   fifo_wdata;
  logic                fifo_wen;
  logic                fifo_wfull;
  logic [N-1:0]        grant;
  logic                busy;

  modport master (
    output en_mask, req_valid, req_data, req_last, fifo_wfull,
    input  req_ready, fifo_wdata, fifo_wen, grant, busy
  );

  modport slave (
    input  en_mask, req_valid, req_data, req_last, fifo_wfull,
    output req_ready, fifo_wdata, fifo_wen, grant, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req searching upward from ptr+1,
// wrapping at N. Purely combinational.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] idx
);

  logic          hit_s;
  logic [PW-1:0] cand_s;

  // Scan the N candidates in priority order starting just after the last owner.
  always_comb begin
    pick   = '0;
    idx    = '0;
    hit_s  = 1'b0;
    cand_s = '0;
    for (int k = 1; k <= N; k++) begin
      cand_s = PW'((int'(ptr) + k) % N);
      if (!hit_s && req[cand_s]) begin
        hit_s        = 1'b1;
        pick[cand_s] = 1'b1;
        idx          = cand_s;
      end else begin
        hit_s = hit_s;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst scheduler sharing one FIFO write port between N requesters.
// fifo_wen is combinational from fifo_wfull so a full FIFO is never written.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BURST = 16,
  parameter int IDW       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(MAX_BURST);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  arb_state_e     state_r, state_n_s;
  logic [N-1:0]   grant_r, grant_n_s;
  logic [PW-1:0]  ptr_r, ptr_n_s;
  logic [CW-1:0]  cnt_r, cnt_n_s;
  logic           busy_r;

  logic [N-1:0]         eligible_s;
  logic [N-1:0]         pick_s;
  logic [PW-1:0]        pick_idx_s;
  logic                 own_valid_s;
  logic                 own_en_s;
  logic                 own_last_s;
  logic [PAYLOAD_W-1:0] own_data_s;
  logic                 beat_s;
  logic [N-1:0]         ready_s;
  logic [WORD_W-1:0]    wdata_s;

  assign eligible_s = bus.req_valid & bus.en_mask;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req  (eligible_s),
    .ptr  (ptr_r),
    .pick (pick_s),
    .idx  (pick_idx_s)
  );

  // Owner's signals selected through the one-hot grant; all zero in IDLE.
  always_comb begin
    own_valid_s = |(bus.req_valid & grant_r);
    own_en_s    = |(bus.en_mask & grant_r);
    own_last_s  = |(bus.req_last & grant_r);
    own_data_s  = '0;
    for (int i = 0; i < N; i++) begin
      own_data_s = own_data_s | (bus.req_data[i*32 +: 32] & {PAYLOAD_W{grant_r[i]}});
    end
  end

  // Next-state and write-port outputs.
  always_comb begin
    state_n_s = state_r;
    grant_n_s = grant_r;
    ptr_n_s   = ptr_r;
    cnt_n_s   = cnt_r;
    ready_s   = '0;
    beat_s    = 1'b0;
    wdata_s   = '0;
    case (state_r)
      ST_IDLE: begin
        if (|eligible_s) begin
          state_n_s = ST_BURST;
          grant_n_s = pick_s;
          ptr_n_s   = pick_idx_s;
          cnt_n_s   = '0;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        ready_s = grant_r & {N{own_en_s & ~bus.fifo_wfull}};
        beat_s  = own_valid_s & own_en_s & ~bus.fifo_wfull;
        wdata_s = pack_word(IDW'(ptr_r), own_last_s, own_data_s);
        if (beat_s) begin
          cnt_n_s = cnt_r + CW'(1);
        end else begin
          cnt_n_s = cnt_r;
        end
        // A full stall with the owner still valid holds the grant.
        if (!own_valid_s || !own_en_s || (beat_s && (own_last_s || cnt_r == CNT_LAST))) begin
          state_n_s = ST_IDLE;
          grant_n_s = '0;
          cnt_n_s   = '0;
        end else begin
          state_n_s = ST_BURST;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
        grant_n_s = '0;
        cnt_n_s   = '0;
      end
    endcase
  end

  // State, grant, round-robin pointer and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      grant_r <= '0;
      ptr_r   <= PW'(N - 1);
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      grant_r <= grant_n_s;
      ptr_r   <= ptr_n_s;
      cnt_r   <= cnt_n_s;
      busy_r  <= (state_n_s == ST_BURST);
    end
  end

  assign bus.req_ready  = ready_s;
  assign bus.fifo_wen   = beat_s;
  assign bus.fifo_wdata = wdata_s;
  assign bus.grant      = grant_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario bench for fifo_wr_arbiter: per-requester source queues drive the
// handshake; every FIFO write is checked against a per-requester expected queue.
module tb_fifo_wr_arbiter;
  import fifo_wr_arb_pkg::*;

  localparam int N  = 4;
  localparam int MB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N(N)) bus();

  fifo_wr_arbiter #(.N(N), .MAX_BURST(MB), .IDW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [32:0] src_q [N][$];
  logic [35:0] exp_q [N][$];
  logic [N-1:0] src_hold;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [N-1:0] obs_grant, obs_ready;
  logic         obs_wen, obs_busy;
  logic [35:0]  obs_wdata;

  task automatic drive();
    logic [32:0] h;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() != 0) begin
        h = src_q[i][0];
        bus.req_valid[i]         = ~src_hold[i];
        bus.req_data[i*32 +: 32] = h[31:0];
        bus.req_last[i]          = h[32];
      end else begin
        bus.req_valid[i]         = 1'b0;
        bus.req_data[i*32 +: 32] = 32'h0;
        bus.req_last[i]          = 1'b0;
      end
    end
  endtask

  task automatic load(input int i, input int n, input bit last_end);
    logic [31:0] d;
    logic        l;
    for (int k = 0; k < n; k++) begin
      d = $urandom;
      l = last_end && (k == n - 1);
      src_q[i].push_back({l, d});
      exp_q[i].push_back({3'(i), l, d});
    end
    drive();
  endtask

  // One clock: sample at negedge, score writes, retire accepted beats after posedge.
  task automatic step();
    logic [N-1:0] acc;
    logic [N-1:0] acc_exp;
    logic [35:0]  e;
    int           id;
    @(negedge clk);
    obs_grant = bus.grant;
    obs_ready = bus.req_ready;
    obs_wen   = bus.fifo_wen;
    obs_busy  = bus.busy;
    obs_wdata = bus.fifo_wdata;
    acc       = bus.req_valid & bus.req_ready;
    if (obs_wen === 1'b1) begin
      id = int'(obs_wdata[35:33]);
      total_cnt++;
      if (id >= N || exp_q[id].size() == 0) begin
        $display("FAIL sb_unexpected: wrote %h, no word expected for id %0d", obs_wdata, id);
      end else begin
        e = exp_q[id].pop_front();
        if (obs_wdata !== e) $display("FAIL sb_word: got %h want %h", obs_wdata, e);
        else pass_cnt++;
      end
    end
    if (obs_wen !== 1'b0 || acc != 4'b0000) begin
      acc_exp = (obs_wen === 1'b1) ? (4'b0001 << obs_wdata[35:33]) : 4'b0000;
      total_cnt++;
      if (acc !== acc_exp) $display("FAIL beat_acct: valid&ready %b want %b (wen %b)", acc, acc_exp, obs_wen);
      else pass_cnt++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) void'(src_q[i].pop_front());
    end
    drive();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      if (all_empty() && obs_busy === 1'b0) done = 1'b1;
      else step();
    end
    total_cnt++;
    if (!done) $display("FAIL %s_drain: queues not empty or busy=%b after 600 cycles", name, obs_busy);
    else pass_cnt++;
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    bus.fifo_wfull = 1'b0;
    bus.en_mask    = {N{1'b1}};
    src_hold       = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();
  endtask

  task automatic test_reset();
    load(0, 2, 1'b1);
    @(negedge clk);
    total_cnt++;
    if ({bus.grant, bus.busy, bus.fifo_wen} !== {4'b0000, 1'b0, 1'b0})
      $display("FAIL reset_ctrl: grant/busy/wen %b%b%b want 000000", bus.grant, bus.busy, bus.fifo_wen);
    else pass_cnt++;
    total_cnt++;
    if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
    else pass_cnt++;
    total_cnt++;
    if (bus.fifo_wdata !== 36'h0) $display("FAIL reset_wdata: got %h want 0", bus.fifo_wdata);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drain("reset");
  endtask

  task automatic test_single_packet();
    apply_reset();
    load(2, 3, 1'b1);
    step();
    total_cnt++;
    if ({obs_grant, obs_busy, obs_wen} !== 6'b000000) $display("FAIL single_pre: grant/busy/wen %b%b%b want 000000", obs_grant, obs_busy, obs_wen);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      step();
      total_cnt++;
      if ({obs_grant, obs_wen, obs_wdata[32]} !== {4'b0100, 1'b1, (k == 2)})
        $display("FAIL single_beat%0d: grant/wen/last %b/%b/%b want 0100/1/%0d", k, obs_grant, obs_wen, obs_wdata[32], k == 2);
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if ({obs_grant, obs_busy, obs_wen} !== 6'b000000) $display("FAIL single_post: grant/busy/wen %b%b%b want 000000", obs_grant, obs_busy, obs_wen);
    else pass_cnt++;
    drain("single");
  endtask

  task automatic test_all_rr();
    int order [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    load(0, 32, 1'b0);
    for (int i = 1; i < N; i++) load(i, MB, 1'b0);
    for (int r = 0; r < 5; r++) begin
      step();
      total_cnt++;
      if ({obs_grant, obs_busy, obs_wen} !== 6'b000000) $display("FAIL rr_gap%0d: grant/busy/wen %b%b%b want 000000", r, obs_grant, obs_busy, obs_wen);
      else pass_cnt++;
      for (int b = 0; b < MB; b++) begin
        step();
        total_cnt++;
        if ({obs_grant, obs_wen, obs_wdata[32]} !== {4'b0001 << order[r], 1'b1, 1'b0})
          $display("FAIL rr_g%0d_b%0d: grant/wen/last %b/%b/%b want %b/1/0", r, b, obs_grant, obs_wen, obs_wdata[32], 4'b0001 << order[r]);
        else pass_cnt++;
      end
    end
    step();
    total_cnt++;
    if ({obs_grant, obs_busy} !== 5'b00000) $display("FAIL rr_end: grant/busy %b%b want 00000", obs_grant, obs_busy);
    else pass_cnt++;
    drain("rr");
  endtask

  task automatic test_full_stall();
    apply_reset();
    load(1, 20, 1'b0);
    step();
    for (int b = 0; b < MB + 5; b++) begin
      if (b == 4) bus.fifo_wfull = 1'b1;
      if (b == 9) bus.fifo_wfull = 1'b0;
      step();
      total_cnt++;
      if (b >= 4 && b < 9) begin
        if ({obs_grant, obs_wen, obs_ready, obs_busy} !== {4'b0010, 1'b0, 4'b0000, 1'b1})
          $display("FAIL stall_c%0d: grant/wen/ready/busy %b/%b/%b/%b want 0010/0/0000/1", b, obs_grant, obs_wen, obs_ready, obs_busy);
        else pass_cnt++;
      end else begin
        if ({obs_grant, obs_wen, obs_wdata[32]} !== {4'b0010, 1'b1, 1'b0})
          $display("FAIL stall_beat%0d: grant/wen/last %b/%b/%b want 0010/1/0", b, obs_grant, obs_wen, obs_wdata[32]);
        else pass_cnt++;
      end
    end
    step();
    total_cnt++;
    if ({obs_grant, obs_busy} !== 5'b00000) $display("FAIL stall_cut: grant/busy %b%b want 00000", obs_grant, obs_busy);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({obs_grant, obs_wen} !== {4'b0010, 1'b1}) $display("FAIL stall_regrant: grant/wen %b/%b want 0010/1", obs_grant, obs_wen);
    else pass_cnt++;
    drain("stall");
  endtask

  task automatic test_owner_drop();
    apply_reset();
    load(0, 6, 1'b0);
    load(3, 4, 1'b1);
    step();
    for (int b = 0; b < 2; b++) begin
      step();
      total_cnt++;
      if ({obs_grant, obs_wen} !== {4'b0001, 1'b1}) $display("FAIL drop_beat%0d: grant/wen %b/%b want 0001/1", b, obs_grant, obs_wen);
      else pass_cnt++;
    end
    src_hold[0] = 1'b1;
    drive();
    step();
    total_cnt++;
    if ({obs_grant, obs_busy, obs_wen} !== {4'b0001, 1'b1, 1'b0}) $display("FAIL drop_cycle: grant/busy/wen %b/%b/%b want 0001/1/0", obs_grant, obs_busy, obs_wen);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({obs_grant, obs_busy} !== 5'b00000) $display("FAIL drop_idle: grant/busy %b%b want 00000", obs_grant, obs_busy);
    else pass_cnt++;
    for (int b = 0; b < 4; b++) begin
      step();
      if (b == 0) begin
        src_hold[0] = 1'b0;
        drive();
      end
      total_cnt++;
      if ({obs_grant, obs_wen, obs_wdata[32]} !== {4'b1000, 1'b1, (b == 3)})
        $display("FAIL drop_r3_b%0d: grant/wen/last %b/%b/%b want 1000/1/%0d", b, obs_grant, obs_wen, obs_wdata[32], b == 3);
      else pass_cnt++;
    end
    step();
    step();
    total_cnt++;
    if ({obs_grant, obs_wen} !== {4'b0001, 1'b1}) $display("FAIL drop_resume: grant/wen %b/%b want 0001/1", obs_grant, obs_wen);
    else pass_cnt++;
    drain("drop");
  endtask

  task automatic test_mask();
    apply_reset();
    bus.en_mask = 4'b1110;
    for (int i = 0; i < N; i++) load(i, 8, 1'b0);
    step();
    for (int b = 0; b < 3; b++) begin
      step();
      total_cnt++;
      if ({obs_grant, obs_wen} !== {4'b0010, 1'b1}) $display("FAIL mask_beat%0d: grant/wen %b/%b want 0010/1", b, obs_grant, obs_wen);
      else pass_cnt++;
    end
    bus.en_mask = 4'b1100;
    step();
    total_cnt++;
    if ({obs_grant, obs_busy, obs_wen, obs_ready} !== {4'b0010, 1'b1, 1'b0, 4'b0000})
      $display("FAIL mask_clear: grant/busy/wen/ready %b/%b/%b/%b want 0010/1/0/0000", obs_grant, obs_busy, obs_wen, obs_ready);
    else pass_cnt++;
    step();
    step();
    total_cnt++;
    if ({obs_grant, obs_wen} !== {4'b0100, 1'b1}) $display("FAIL mask_move: grant/wen %b/%b want 0100/1", obs_grant, obs_wen);
    else pass_cnt++;
    for (int c = 0; c < 40; c++) begin
      step();
      total_cnt++;
      if ({obs_grant[0], obs_ready[0]} !== 2'b00) $display("FAIL mask_r0_c%0d: grant0/ready0 %b%b want 00", c, obs_grant[0], obs_ready[0]);
      else pass_cnt++;
    end
    total_cnt++;
    if (src_q[0].size() != 8) $display("FAIL mask_r0_left: %0d words left want 8", src_q[0].size());
    else pass_cnt++;
    bus.en_mask = 4'b1111;
    drain("mask");
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    load(0, 20, 1'b0);
    load(1, 4, 1'b1);
    step();
    for (int b = 0; b < 7; b++) begin
      step();
      total_cnt++;
      if ({obs_grant, obs_wen} !== {4'b0001, 1'b1}) $display("FAIL rstmid_beat%0d: grant/wen %b/%b want 0001/1", b, obs_grant, obs_wen);
      else pass_cnt++;
    end
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.grant, bus.fifo_wen, bus.req_ready, bus.busy} !== 10'b0)
      $display("FAIL rstmid_drop: grant/wen/ready/busy %b/%b/%b/%b want 0000/0/0000/0", bus.grant, bus.fifo_wen, bus.req_ready, bus.busy);
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    step();
    total_cnt++;
    if ({obs_grant, obs_busy} !== 5'b00000) $display("FAIL rstmid_idle: grant/busy %b%b want 00000", obs_grant, obs_busy);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({obs_grant, obs_wen} !== {4'b0001, 1'b1}) $display("FAIL rstmid_first: grant/wen %b/%b want 0001/1", obs_grant, obs_wen);
    else pass_cnt++;
    drain("rstmid");
  endtask

  initial begin
    bus.en_mask    = {N{1'b1}};
    bus.fifo_wfull = 1'b0;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.req_last   = '0;
    src_hold       = '0;
    obs_busy       = 1'b0;
    test_reset();
    test_single_packet();
    test_all_rr();
    test_full_stall();
    test_owner_drop();
    test_mask();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
